balu_bitcount_seq: RTL and testbench

//  Multi-cycle bit-count engine for the RISCV 32B count ops (CLZ, CPOP, CTZ).

---
 rtl/balu_bitcount_seq.sv | 177 +++++++++++++++++
 tb/tb_balu_bitcount_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/balu_bitcount_seq.sv
// -----------------------------------------------------------------------------
// balu_bitcount_seq
//   Multi-cycle bit-count engine for the RISC-V count ops CLZ, CPOP and CTZ.
//   Accepts one request at a time over a valid/ready pair, scans STEP bits of
//   the captured operand per cycle and returns the count over a second
//   valid/ready pair. mode_sel codes match the combinational bit unit.
//
// Parameters
//   WIDTH     operand width; result range 0..WIDTH
//   STEP      bits examined per cycle (1, 2, 4 or 8; must divide WIDTH)
//
// Ports
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous reset, active low
//   in_valid   in   1      request valid
//   in_ready   out  1      request accepted when high (IDLE only)
//   mode_sel   in   8      8'h34 CLZ, 8'h35 CPOP, 8'h36 CTZ; others illegal
//   num1       in   WIDTH  source operand, captured at the request handshake
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer takes the result
//   ans        out  32     zero-extended count, stable while out_valid is high
//   error      out  1      illegal mode_sel, qualified by out_valid
// -----------------------------------------------------------------------------
module balu_bitcount_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       mode_sel,
    input  logic [WIDTH-1:0] num1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      ans,
    output logic             error
);

    localparam int unsigned N    = WIDTH / STEP;
    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam int unsigned CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Low two bits of the legal mode codes 8'h34/35/36 give 0/1/2 directly.
    localparam logic [1:0] OP_CLZ  = 2'd0;
    localparam logic [1:0] OP_CPOP = 2'd1;
    localparam logic [1:0] OP_CTZ  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       op;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNTW-1:0]  cnt;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    acc_next;
    logic             seen;
    logic             seen_next;
    logic             mode_legal;
    logic [STEP-1:0]  chunk_hi;
    logic [STEP-1:0]  chunk_lo;

    function automatic logic [CW-1:0] lead_zeros(input logic [STEP-1:0] c);
        logic found;
        lead_zeros = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (!found) begin
                if (c[STEP-1-i]) found = 1'b1;
                else             lead_zeros = lead_zeros + 1'b1;
            end
        end
    endfunction

    function automatic logic [CW-1:0] trail_zeros(input logic [STEP-1:0] c);
        logic found;
        trail_zeros = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (!found) begin
                if (c[i]) found = 1'b1;
                else      trail_zeros = trail_zeros + 1'b1;
            end
        end
    endfunction

    function automatic logic [CW-1:0] pop_count(input logic [STEP-1:0] c);
        pop_count = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            pop_count = pop_count + CW'(c[i]);
        end
    endfunction

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign mode_legal = (mode_sel == 8'h34) || (mode_sel == 8'h35) || (mode_sel == 8'h36);
    assign chunk_hi   = shreg[WIDTH-1 -: STEP];
    assign chunk_lo   = shreg[STEP-1:0];

    // CLZ consumes the operand MSB-first (shift left); CTZ and CPOP LSB-first.
    // Once a one has been seen the zero-count ops stop accumulating.
    always_comb begin
        acc_next   = acc;
        seen_next  = seen;
        shreg_next = shreg >> STEP;
        case (op)
            OP_CLZ: begin
                shreg_next = shreg << STEP;
                if (!seen) begin
                    acc_next  = acc + lead_zeros(chunk_hi);
                    seen_next = |chunk_hi;
                end
            end
            OP_CTZ: begin
                if (!seen) begin
                    acc_next  = acc + trail_zeros(chunk_lo);
                    seen_next = |chunk_lo;
                end
            end
            default: begin
                acc_next = acc + pop_count(chunk_lo);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            op    <= OP_CLZ;
            shreg <= '0;
            cnt   <= '0;
            acc   <= '0;
            seen  <= 1'b0;
            ans   <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (mode_legal) begin
                            state <= S_BUSY;
                            op    <= mode_sel[1:0];
                            shreg <= num1;
                            cnt   <= '0;
                            acc   <= '0;
                            seen  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            ans   <= '0;
                            error <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    shreg <= shreg_next;
                    acc   <= acc_next;
                    seen  <= seen_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CHUNK) begin
                        state <= S_DONE;
                        ans   <= 32'(acc_next);
                        error <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_balu_bitcount_seq.sv
// -----------------------------------------------------------------------------
// tb_balu_bitcount_seq
//   Self-checking bench for balu_bitcount_seq at default parameters. Results
//   are compared against a bit-loop reference model of CLZ/CPOP/CTZ; latency,
//   backpressure, input capture and mid-operation reset are also checked.
// -----------------------------------------------------------------------------
module tb_balu_bitcount_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned NCHK  = WIDTH / STEP;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       mode_sel;
    logic [WIDTH-1:0] num1;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      ans;
    logic             error;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    balu_bitcount_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_sel  (mode_sel),
        .num1      (num1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d (0x%08h) expected=%0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference: count bits one at a time over the whole operand.
    task automatic ref_model(input logic [7:0] mode, input logic [31:0] data,
                             output logic [31:0] exp_ans, output logic exp_err);
        int n;
        exp_err = 1'b0;
        n = 0;
        case (mode)
            8'h34: begin
                for (int i = WIDTH - 1; i >= 0 && data[i] == 1'b0; i--) n++;
            end
            8'h35: begin
                for (int i = 0; i < WIDTH; i++) n += int'(data[i]);
            end
            8'h36: begin
                for (int i = 0; i < WIDTH && data[i] == 1'b0; i++) n++;
            end
            default: exp_err = 1'b1;
        endcase
        exp_ans = 32'(n);
    endtask

    // One full request/response; num1/mode_sel are scrambled after the
    // handshake so a result that depends on them after capture is caught.
    task automatic run_op(input logic [7:0] mode, input logic [31:0] data,
                          input int unsigned hold);
        logic [31:0] exp_ans;
        logic        exp_err;
        int unsigned lat;
        ref_model(mode, data, exp_ans, exp_err);
        @(negedge clk);
        in_valid = 1'b1;
        mode_sel = mode;
        num1     = data;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode_sel = 8'($urandom);
        num1     = ~data;
        lat = 0;
        while (!out_valid && lat < 64) begin
            if (in_ready) check("in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            num1 = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        if (exp_err) check("latency_illegal", lat, 32'd0);
        else         check("latency_legal", lat, NCHK);
        check("ans", ans, exp_ans);
        check("error", 32'(error), 32'(exp_err));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int unsigned k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ans", ans, exp_ans);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_resp", 32'(in_ready), 32'd1);
        check("out_valid_after_resp", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0]  rmode;
        logic [31:0] rdata;
        logic        spurious;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        mode_sel  = 8'h00;
        num1      = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ans", ans, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed cases
        run_op(8'h34, 32'h0001_0000, 0);
        run_op(8'h36, 32'h0000_0000, 0);
        run_op(8'h34, 32'h0000_0000, 0);
        run_op(8'h35, 32'h0000_0000, 0);
        run_op(8'h34, 32'h8000_0000, 0);
        run_op(8'h36, 32'h8000_0000, 0);
        run_op(8'h35, 32'hFFFF_FFFF, 0);
        run_op(8'h34, 32'hFFFF_FFFF, 0);
        run_op(8'h36, 32'hFFFF_FFFF, 0);
        run_op(8'h35, 32'hA5A5_0F01, 0);
        run_op(8'h30, 32'h1234_5678, 0);
        run_op(8'h37, 32'h0000_0000, 2);
        run_op(8'h35, 32'h0000_00FF, 5);

        // Reset while BUSY at chunk 4
        @(negedge clk);
        in_valid = 1'b1;
        mode_sel = 8'h34;
        num1     = 32'h0000_1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_ans", ans, 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        spurious = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious = 1'b1;
        end
        check("midrst_no_response", 32'(spurious), 32'd0);
        run_op(8'h34, 32'h0000_0001, 0);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       rmode = 8'($urandom);
                1, 2, 3: rmode = 8'h34;
                4, 5, 6: rmode = 8'h35;
                default: rmode = 8'h36;
            endcase
            case ($urandom_range(0, 3))
                0:       rdata = $urandom;
                1:       rdata = $urandom >> $urandom_range(0, 31);
                2:       rdata = $urandom << $urandom_range(0, 31);
                default: rdata = 32'h1 << $urandom_range(0, 31);
            endcase
            run_op(rmode, rdata, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
